// File: rtl/mux_wd_seq.sv
// Registered write-data selector for the register-file write port.
// Picks one of N_SRC sources, sizes/extends it, and waits (bounded) on slow sources.
module mux_wd_seq #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned N_SRC    = 6,
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req,
    input  logic [SEL_W-1:0]        sel,
    input  logic [1:0]              size,
    input  logic                    sign_ext,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    input  logic [N_SRC-1:0]        src_ready,
    output logic                    busy,
    output logic                    wd_valid,
    output logic [DATA_W-1:0]       wd_out,
    output logic [1:0]              err
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_BAD_SEL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [1:0]        size_q, size_d;
    logic              sext_q, sext_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] wd_out_q, wd_out_d;
    logic [1:0]        err_q, err_d;

    logic [SEL_W-1:0]  ch_sel;
    logic [1:0]        ch_size;
    logic              ch_sext;
    logic [DATA_W-1:0] ch_data;
    logic              ch_ready;
    logic              sel_ok;

    // Word passes through; half/byte take the low bits and fill with sign or zero.
    function automatic logic [DATA_W-1:0] size_ext(input logic [DATA_W-1:0] d,
                                                   input logic [1:0]        sz,
                                                   input logic              sx);
        logic [DATA_W-1:0] r;
        case (sz)
            2'b01:   r = {{(DATA_W-16){sx & d[15]}}, d[15:0]};
            2'b10:   r = {{(DATA_W-8){sx & d[7]}}, d[7:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Channel mux: live inputs in IDLE, latched request fields in WAIT.
    always_comb begin
        ch_sel   = (state_q == ST_WAIT) ? sel_q : sel;
        ch_size  = (state_q == ST_WAIT) ? size_q : size;
        ch_sext  = (state_q == ST_WAIT) ? sext_q : sign_ext;
        ch_data  = '0;
        ch_ready = 1'b0;
        sel_ok   = 1'b0;
        // Out-of-range selectors match no channel, so nothing is indexed past N_SRC.
        for (int k = 0; k < int'(N_SRC); k++) begin
            if (ch_sel == SEL_W'(k)) begin
                ch_data  = src_data[k*DATA_W +: DATA_W];
                ch_ready = src_ready[k];
                sel_ok   = 1'b1;
            end
        end
    end

    // Next-state logic for the IDLE/WAIT controller and the result registers.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        size_d   = size_q;
        sext_d   = sext_q;
        valid_d  = 1'b0;
        wd_out_d = wd_out_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (!sel_ok) begin
                        valid_d  = 1'b1;
                        err_d    = ERR_BAD_SEL;
                        wd_out_d = '0;
                    end else if (ch_ready) begin
                        valid_d  = 1'b1;
                        err_d    = ERR_OK;
                        wd_out_d = size_ext(ch_data, ch_size, ch_sext);
                    end else begin
                        sel_d   = sel;
                        size_d  = size;
                        sext_d  = sign_ext;
                        cnt_d   = '0;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Ready takes priority over a timeout in the same cycle.
                if (ch_ready) begin
                    valid_d  = 1'b1;
                    err_d    = ERR_OK;
                    wd_out_d = size_ext(ch_data, ch_size, ch_sext);
                    state_d  = ST_IDLE;
                end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                    valid_d  = 1'b1;
                    err_d    = ERR_TIMEOUT;
                    wd_out_d = '0;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset overrides any in-flight request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sel_q    <= '0;
            size_q   <= '0;
            sext_q   <= 1'b0;
            valid_q  <= 1'b0;
            wd_out_q <= '0;
            err_q    <= ERR_OK;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            size_q   <= size_d;
            sext_q   <= sext_d;
            valid_q  <= valid_d;
            wd_out_q <= wd_out_d;
            err_q    <= err_d;
        end
    end

    assign busy     = (state_q == ST_WAIT);
    assign wd_valid = valid_q;
    assign wd_out   = wd_out_q;
    assign err      = err_q;

endmodule
